// File: rtl/gt_rx_link_fsm_if.sv
// GT receive port bundle between the transceiver RX side and the link supervisor.
//   rx_data      : 16-bit RX word
//   rx_k         : per-byte K flags for rx_data
//   rx_aligned   : comma aligner reports byte alignment
//   rx_bufstatus : RX elastic buffer status code
//   rx_realign   : one-cycle comma realign request back to the GT
// master = transceiver side, slave = link supervisor.
interface gt_rx_link_fsm_if;
  logic [15:0] rx_data;
  logic [1:0]  rx_k;
  logic        rx_aligned;
  logic [2:0]  rx_bufstatus;
  logic        rx_realign;

  modport master (
    output rx_data,
    output rx_k,
    output rx_aligned,
    output rx_bufstatus,
    input  rx_realign
  );

  modport slave (
    input  rx_data,
    input  rx_k,
    input  rx_aligned,
    input  rx_bufstatus,
    output rx_realign
  );
endinterface

// File: rtl/gt_rx_link_fsm.sv
// Receive-side link supervisor for a GTP RX port (elastic buffer + comma aligner enabled).
// Hunts for byte alignment, requires a run of good IDLE words before declaring the link up,
// forwards payload words while locked and counts comma, buffer and relock events.
//   usrclk_i        : GT user clock, only clock
//   rst_n_i         : asynchronous active-low reset
//   en_i            : link enable, low forces IDLE
//   gt              : GT RX bundle (data, K flags, aligned, buffer status, realign request)
//   link_up_o       : high only in LOCKED
//   data_o          : forwarded payload word, qualified by data_valid_o
//   state_o         : 0 IDLE, 1 HUNT, 2 SYNC, 3 LOCKED
//   err_comma_cnt_o : misaligned-K events (saturating)
//   err_buf_cnt_o   : buffer over/underflow events (saturating)
//   relock_cnt_o    : LOCKED to HUNT transitions (saturating)
module gt_rx_link_fsm #(
  parameter logic [15:0] g_IDLE            = 16'hbc95,
  parameter logic [1:0]  g_IDLE_K          = 2'b10,
  parameter int unsigned g_LOCK_IDLES      = 16,
  parameter int unsigned g_IDLE_TIMEOUT    = 256,
  parameter int unsigned g_REALIGN_HOLDOFF = 64,
  parameter int unsigned g_CNT_WIDTH       = 16
) (
  input  logic                   usrclk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  gt_rx_link_fsm_if.slave        gt,
  output logic                   link_up_o,
  output logic [15:0]            data_o,
  output logic                   data_valid_o,
  output logic [1:0]             state_o,
  output logic [g_CNT_WIDTH-1:0] err_comma_cnt_o,
  output logic [g_CNT_WIDTH-1:0] err_buf_cnt_o,
  output logic [g_CNT_WIDTH-1:0] relock_cnt_o
);

  localparam int unsigned HoldW = (g_REALIGN_HOLDOFF > 2) ? $clog2(g_REALIGN_HOLDOFF) : 1;
  localparam int unsigned GoodW = $clog2(g_LOCK_IDLES + 1);
  localparam int unsigned ToW   = $clog2(g_IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHunt   = 2'd1,
    StSync   = 2'd2,
    StLocked = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [GoodW-1:0]       good_cnt_q, good_cnt_d;
  logic [ToW-1:0]         to_cnt_q, to_cnt_d;
  logic                   realign_q, realign_d;
  logic                   link_up_q, link_up_d;
  logic [15:0]            data_q, data_d;
  logic                   valid_q, valid_d;
  logic [g_CNT_WIDTH-1:0] comma_cnt_q, comma_cnt_d;
  logic [g_CNT_WIDTH-1:0] buf_cnt_q, buf_cnt_d;
  logic [g_CNT_WIDTH-1:0] relock_cnt_q, relock_cnt_d;

  logic good_idle, payload, bad_k, buf_err, timeout, link_fail, hold_wrap, in_sync_lock;

  // Word classification and exit conditions, shared by next-state and output logic.
  assign good_idle    = (gt.rx_k == g_IDLE_K) && (gt.rx_data == g_IDLE);
  assign payload      = (gt.rx_k == 2'b00);
  assign bad_k        = !good_idle && !payload;
  // 001/010 are clock-correction warnings, not errors.
  assign buf_err      = (gt.rx_bufstatus == 3'b101) || (gt.rx_bufstatus == 3'b110);
  // Fires on the cycle the non-IDLE run length reaches g_IDLE_TIMEOUT.
  assign timeout      = !good_idle && (to_cnt_q == ToW'(g_IDLE_TIMEOUT - 1));
  assign link_fail    = bad_k || buf_err || !gt.rx_aligned || timeout;
  assign hold_wrap    = (hold_cnt_q == HoldW'(g_REALIGN_HOLDOFF - 1));
  assign in_sync_lock = (state_q == StSync) || (state_q == StLocked);

  // State register.
  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; en_i low overrides everything.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StHunt;
        StHunt: if (gt.rx_aligned) state_d = StSync;
        StSync: begin
          if (link_fail) begin
            state_d = StHunt;
          end else if (good_idle && (good_cnt_q == GoodW'(g_LOCK_IDLES - 1))) begin
            state_d = StLocked;
          end
        end
        StLocked: if (link_fail) state_d = StHunt;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output and counter next-state logic.
  always_comb begin
    hold_cnt_d   = '0;
    good_cnt_d   = '0;
    to_cnt_d     = '0;
    realign_d    = 1'b0;
    link_up_d    = (state_d == StLocked);
    valid_d      = 1'b0;
    data_d       = data_q;
    comma_cnt_d  = comma_cnt_q;
    buf_cnt_d    = buf_cnt_q;
    relock_cnt_d = relock_cnt_q;

    // Realign holdoff only runs in HUNT and only while enable keeps us there.
    if ((state_q == StHunt) && en_i && !gt.rx_aligned) begin
      if (hold_wrap) begin
        realign_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end

    if (state_q == StSync) begin
      good_cnt_d = (good_idle && !link_fail) ? good_cnt_q + 1'b1 : good_cnt_q;
    end

    if (in_sync_lock && !good_idle && !timeout) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // Only clean payload in LOCKED is forwarded; any exit condition suppresses it.
    if ((state_q == StLocked) && en_i && payload && !link_fail) begin
      valid_d = 1'b1;
      data_d  = gt.rx_data;
    end

    if (in_sync_lock && bad_k && (comma_cnt_q != '1)) begin
      comma_cnt_d = comma_cnt_q + 1'b1;
    end
    if ((state_q != StIdle) && buf_err && (buf_cnt_q != '1)) begin
      buf_cnt_d = buf_cnt_q + 1'b1;
    end
    if ((state_q == StLocked) && (state_d == StHunt) && (relock_cnt_q != '1)) begin
      relock_cnt_d = relock_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_cnt_q   <= '0;
      good_cnt_q   <= '0;
      to_cnt_q     <= '0;
      realign_q    <= 1'b0;
      link_up_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      comma_cnt_q  <= '0;
      buf_cnt_q    <= '0;
      relock_cnt_q <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      good_cnt_q   <= good_cnt_d;
      to_cnt_q     <= to_cnt_d;
      realign_q    <= realign_d;
      link_up_q    <= link_up_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      comma_cnt_q  <= comma_cnt_d;
      buf_cnt_q    <= buf_cnt_d;
      relock_cnt_q <= relock_cnt_d;
    end
  end

  assign gt.rx_realign   = realign_q;
  assign link_up_o       = link_up_q;
  assign data_o          = data_q;
  assign data_valid_o    = valid_q;
  assign state_o         = state_q;
  assign err_comma_cnt_o = comma_cnt_q;
  assign err_buf_cnt_o   = buf_cnt_q;
  assign relock_cnt_o    = relock_cnt_q;

endmodule

// File: tb/tb_gt_rx_link_fsm.sv
// Directed bench for gt_rx_link_fsm with default parameters.
module tb_gt_rx_link_fsm;

  localparam logic [15:0] Idle  = 16'hbc95;
  localparam logic [1:0]  IdleK = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        link_up;
  logic [15:0] data;
  logic        valid;
  logic [1:0]  state;
  logic [15:0] comma_cnt, buf_cnt, relock_cnt;

  int total = 0;
  int bad = 0;

  gt_rx_link_fsm_if gt ();

  always #5 clk = ~clk;

  gt_rx_link_fsm dut (
    .usrclk_i        (clk),
    .rst_n_i         (rst_n),
    .en_i            (en),
    .gt              (gt),
    .link_up_o       (link_up),
    .data_o          (data),
    .data_valid_o    (valid),
    .state_o         (state),
    .err_comma_cnt_o (comma_cnt),
    .err_buf_cnt_o   (buf_cnt),
    .relock_cnt_o    (relock_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [1:0] k, input logic [15:0] d);
    gt.rx_k    = k;
    gt.rx_data = d;
  endtask

  // Bring the link to LOCKED from wherever it is, with a bounded wait.
  task automatic lock_quiet();
    en = 1'b1;
    gt.rx_aligned = 1'b1;
    gt.rx_bufstatus = 3'b000;
    set_word(IdleK, Idle);
    for (int i = 0; i < 40 && state !== 2'd3; i++) tick();
    total++;
    if (state !== 2'd3) begin
      bad++; $display("FAIL lock_wait state=%0d want=3", state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    gt.rx_aligned = 1'b0;
    gt.rx_bufstatus = 3'b000;
    set_word(IdleK, Idle);
    #12;
    total++;
    if (state !== 2'd0 || link_up !== 1'b0 || valid !== 1'b0 || data !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs state=%0d link=%b valid=%b data=%h want 0/0/0/0000",
               state, link_up, valid, data);
    end
    total++;
    if (comma_cnt !== 16'd0 || buf_cnt !== 16'd0 || relock_cnt !== 16'd0 ||
        gt.rx_realign !== 1'b0) begin
      bad++;
      $display("FAIL reset_counters comma=%0d buf=%0d relock=%0d realign=%b want 0",
               comma_cnt, buf_cnt, relock_cnt, gt.rx_realign);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    total++;
    if (state !== 2'd0) begin
      bad++; $display("FAIL disabled_stays_idle state=%0d want=0", state);
    end
  endtask

  task automatic test_lock();
    en = 1'b1;
    gt.rx_aligned = 1'b1;
    set_word(IdleK, Idle);
    tick();
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL lock_hunt state=%0d want=1", state);
    end
    tick();
    total++;
    if (state !== 2'd2) begin
      bad++; $display("FAIL lock_sync state=%0d want=2", state);
    end
    repeat (15) tick();
    total++;
    if (state !== 2'd2 || link_up !== 1'b0) begin
      bad++; $display("FAIL lock_15_idles state=%0d link=%b want 2/0", state, link_up);
    end
    tick();
    total++;
    if (state !== 2'd3 || link_up !== 1'b1 || relock_cnt !== 16'd0) begin
      bad++;
      $display("FAIL lock_16_idles state=%0d link=%b relock=%0d want 3/1/0",
               state, link_up, relock_cnt);
    end
  endtask

  task automatic test_payload();
    int n_err;
    set_word(2'b00, 16'h1234);
    tick();
    total++;
    if (data !== 16'h1234 || valid !== 1'b1) begin
      bad++; $display("FAIL payload_fwd data=%h valid=%b want 1234/1", data, valid);
    end
    set_word(IdleK, Idle);
    tick();
    total++;
    if (data !== 16'h1234 || valid !== 1'b0) begin
      bad++; $display("FAIL idle_not_fwd data=%h valid=%b want 1234/0", data, valid);
    end
    // Payload stream with an IDLE every 193rd word; must stay locked.
    n_err = 0;
    for (int i = 0; i < 300; i++) begin
      if (i % 193 == 192) set_word(IdleK, Idle);
      else set_word(2'b00, 16'h4000 + 16'(i));
      tick();
      if (i % 193 == 192) begin
        if (valid !== 1'b0) n_err++;
      end else if (valid !== 1'b1 || data !== 16'h4000 + 16'(i)) begin
        n_err++;
      end
    end
    total++;
    if (n_err != 0 || state !== 2'd3) begin
      bad++; $display("FAIL payload_stream errs=%0d state=%0d want 0/3", n_err, state);
    end
  endtask

  task automatic test_misalign();
    set_word(2'b01, 16'h95bc);
    tick();
    total++;
    if (state !== 2'd1 || link_up !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL misalign_exit state=%0d link=%b valid=%b want 1/0/0", state, link_up, valid);
    end
    total++;
    if (comma_cnt !== 16'd1 || relock_cnt !== 16'd1 || buf_cnt !== 16'd0) begin
      bad++;
      $display("FAIL misalign_counts comma=%0d relock=%0d buf=%0d want 1/1/0",
               comma_cnt, relock_cnt, buf_cnt);
    end
  endtask

  task automatic test_realign();
    int pulses, first, prev, gap_bad;
    gt.rx_aligned = 1'b0;
    set_word(IdleK, Idle);
    pulses = 0; first = -1; prev = 0; gap_bad = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (gt.rx_realign === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        else if (i - prev != 64) gap_bad++;
        prev = i;
      end
    end
    total++;
    if (pulses != 3 || first != 64 || gap_bad != 0) begin
      bad++;
      $display("FAIL realign_pulses count=%0d first=%0d gap_bad=%0d want 3/64/0",
               pulses, first, gap_bad);
    end
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL realign_state state=%0d want=1", state);
    end
  endtask

  task automatic test_buffer();
    lock_quiet();
    gt.rx_bufstatus = 3'b110;
    tick();
    gt.rx_bufstatus = 3'b000;
    total++;
    if (buf_cnt !== 16'd1 || state !== 2'd1 || relock_cnt !== 16'd2 || valid !== 1'b0) begin
      bad++;
      $display("FAIL buf_overflow buf=%0d state=%0d relock=%0d valid=%b want 1/1/2/0",
               buf_cnt, state, relock_cnt, valid);
    end
    lock_quiet();
    gt.rx_bufstatus = 3'b001;
    repeat (10) tick();
    gt.rx_bufstatus = 3'b000;
    total++;
    if (state !== 2'd3 || buf_cnt !== 16'd1) begin
      bad++; $display("FAIL buf_clk_corr state=%0d buf=%0d want 3/1", state, buf_cnt);
    end
  endtask

  task automatic test_timeout();
    set_word(2'b00, 16'h0abc);
    repeat (255) tick();
    total++;
    if (state !== 2'd3 || valid !== 1'b1) begin
      bad++; $display("FAIL timeout_255 state=%0d valid=%b want 3/1", state, valid);
    end
    tick();
    total++;
    if (state !== 2'd1 || valid !== 1'b0 || relock_cnt !== 16'd3 || data !== 16'h0abc) begin
      bad++;
      $display("FAIL timeout_256 state=%0d valid=%b relock=%0d data=%h want 1/0/3/0abc",
               state, valid, relock_cnt, data);
    end
  endtask

  task automatic test_both_errors();
    lock_quiet();
    set_word(2'b01, 16'h95bc);
    gt.rx_bufstatus = 3'b101;
    tick();
    gt.rx_bufstatus = 3'b000;
    total++;
    if (comma_cnt !== 16'd2 || buf_cnt !== 16'd2 || relock_cnt !== 16'd4 || state !== 2'd1) begin
      bad++;
      $display("FAIL both_errors comma=%0d buf=%0d relock=%0d state=%0d want 2/2/4/1",
               comma_cnt, buf_cnt, relock_cnt, state);
    end
  endtask

  task automatic test_enable();
    int pulses;
    set_word(IdleK, Idle);
    gt.rx_aligned = 1'b1;
    tick();
    total++;
    if (state !== 2'd2) begin
      bad++; $display("FAIL en_sync state=%0d want=2", state);
    end
    en = 1'b0;
    tick();
    total++;
    if (state !== 2'd0 || link_up !== 1'b0) begin
      bad++; $display("FAIL en_drop state=%0d link=%b want 0/0", state, link_up);
    end
    gt.rx_aligned = 1'b0;
    pulses = 0;
    repeat (100) begin
      tick();
      if (gt.rx_realign === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || state !== 2'd0) begin
      bad++; $display("FAIL en_no_realign pulses=%0d state=%0d want 0/0", pulses, state);
    end
    en = 1'b1;
    tick();
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL en_restart state=%0d want=1", state);
    end
  endtask

  task automatic test_reset_mid();
    lock_quiet();
    set_word(2'b00, 16'hbeef);
    tick();
    total++;
    if (valid !== 1'b1 || data !== 16'hbeef) begin
      bad++; $display("FAIL pre_reset data=%h valid=%b want beef/1", data, valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (state !== 2'd0 || link_up !== 1'b0 || valid !== 1'b0 || data !== 16'h0 ||
        comma_cnt !== 16'd0 || buf_cnt !== 16'd0 || relock_cnt !== 16'd0) begin
      bad++;
      $display("FAIL async_reset state=%0d link=%b valid=%b data=%h c=%0d b=%0d r=%0d want 0",
               state, link_up, valid, data, comma_cnt, buf_cnt, relock_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_payload();
    test_misalign();
    test_realign();
    test_buffer();
    test_timeout();
    test_both_errors();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
